// File: rtl/pc_gen_if.sv
// Fetch-bus bundle between the PC generator and the instruction-side bus master.
interface pc_gen_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  ce;
    logic                  inst_req_o;
    logic                  addr_ok_i;

    modport master (
        output pc,
        output ce,
        output inst_req_o,
        input  addr_ok_i
    );

    modport slave (
        input  pc,
        input  ce,
        input  inst_req_o,
        output addr_ok_i
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential fetch, flush/branch redirect and a
// one-entry buffer that holds a branch target resolved while fetch is stalled.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_OFF  | in reset, ce=0, pc=RESET_VECTOR
// ST_BOOT | first cycle out of reset, ce=1, pc still RESET_VECTOR
// ST_RUN  | normal fetch, pc advances / redirects
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INST_BYTES   = 4,
    parameter int                    STALL_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WIDTH-1:0] stall,
    input  logic                   flush_i,
    input  logic [ADDR_WIDTH-1:0]  flush_pc_i,
    input  logic                   branch_flag_i,
    input  logic [ADDR_WIDTH-1:0]  branch_target_addr_i,
    pc_gen_if.master               fetch,
    output logic                   pend_valid_o,
    output logic                   misalign_o
);

    localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INST_BYTES);
    // Low address bits that must be zero for an aligned fetch (none when INST_BYTES=1).
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  misalign_q, misalign_d;
    logic                  advance;
    logic                  ce;
    logic                  stall_unused;

    // Only the PC-stage bit of the stall vector matters here.
    assign stall_unused = ^stall;

    // Next-state, next-pc and pending-buffer selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        advance      = 1'b0;
        case (state_q)
            ST_OFF:  state_d = ST_BOOT;
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                advance = ~stall[0] & fetch.addr_ok_i;
                if (flush_i) begin
                    pc_d         = flush_pc_i;
                    pend_valid_d = 1'b0;
                end else if (advance) begin
                    if (branch_flag_i) begin
                        pc_d = branch_target_addr_i;
                    end else if (pend_valid_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        pc_d = pc_q + INC;
                    end
                    pend_valid_d = 1'b0;
                end else if (branch_flag_i) begin
                    // Fetch cannot move this cycle; keep the newest target for later.
                    pend_valid_d = 1'b1;
                    pend_addr_d  = branch_target_addr_i;
                end
            end
            default: state_d = ST_OFF;
        endcase
        misalign_d = |(pc_d & ALIGN_MASK);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            misalign_q   <= |(RESET_VECTOR & ALIGN_MASK);
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            misalign_q   <= misalign_d;
        end
    end

    assign ce               = (state_q != ST_OFF);
    assign fetch.ce         = ce;
    assign fetch.pc         = pc_q;
    assign fetch.inst_req_o = ce & ~stall[0];
    assign pend_valid_o     = pend_valid_q;
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic compared
// against a cycle-level reference model of the fetch-address rules.
module tb_pc_gen;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [15:0] RV2 = 16'hFFFE;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_addr_i;
    logic        pend_valid_o;
    logic        misalign_o;

    logic        rst2;
    logic [5:0]  stall2;
    logic        flush2;
    logic [15:0] flush_pc2;
    logic        branch2;
    logic [15:0] target2;
    logic        pend_valid2;
    logic        misalign2;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_if #(.ADDR_WIDTH(32)) fb ();
    pc_gen_if #(.ADDR_WIDTH(16)) fb2 ();

    pc_gen #(
        .ADDR_WIDTH(32), .RESET_VECTOR(RV), .INST_BYTES(4), .STALL_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .branch_flag_i(branch_flag_i), .branch_target_addr_i(branch_target_addr_i),
        .fetch(fb.master), .pend_valid_o(pend_valid_o), .misalign_o(misalign_o)
    );

    pc_gen #(
        .ADDR_WIDTH(16), .RESET_VECTOR(RV2), .INST_BYTES(2), .STALL_WIDTH(6)
    ) dut16 (
        .clk(clk), .rst(rst2), .stall(stall2), .flush_i(flush2), .flush_pc_i(flush_pc2),
        .branch_flag_i(branch2), .branch_target_addr_i(target2),
        .fetch(fb2.master), .pend_valid_o(pend_valid2), .misalign_o(misalign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles since reset release, current pc and the pending target.
    int          m_cycles = 0;
    logic [31:0] m_pc     = RV;
    bit          m_pend   = 0;
    logic [31:0] m_pend_addr = '0;

    task automatic model_step();
        bit adv;
        if (rst) begin
            m_cycles = 0;
            m_pc     = RV;
            m_pend   = 0;
            return;
        end
        if (m_cycles < 2) begin
            m_cycles = m_cycles + 1;
            return;
        end
        adv = !stall[0] && fb.addr_ok_i;
        if (flush_i) begin
            m_pc   = flush_pc_i;
            m_pend = 0;
        end else if (adv) begin
            if (branch_flag_i)  m_pc = branch_target_addr_i;
            else if (m_pend)    m_pc = m_pend_addr;
            else                m_pc = m_pc + 32'd4;
            m_pend = 0;
        end else if (branch_flag_i) begin
            m_pend      = 1;
            m_pend_addr = branch_target_addr_i;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; flush_i = 0; branch_flag_i = 0; fb.addr_ok_i = 1'b1;
        repeat (3) cycle();
        n_tests++; if (fb.pc !== RV) begin n_fail++; $display("FAIL reset_pc got %h want %h", fb.pc, RV); end
        n_tests++; if (fb.ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", fb.ce); end
        n_tests++; if (fb.inst_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", fb.inst_req_o); end
        n_tests++; if (pend_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b want 0", pend_valid_o); end
        n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
        rst = 1'b0;
        cycle();
        n_tests++; if (fb.ce !== 1'b1) begin n_fail++; $display("FAIL boot_ce got %b want 1", fb.ce); end
        n_tests++; if (fb.pc !== RV) begin n_fail++; $display("FAIL boot_pc got %h want %h", fb.pc, RV); end
        cycle();
        n_tests++; if (fb.pc !== RV) begin n_fail++; $display("FAIL run0_pc got %h want %h", fb.pc, RV); end
        cycle();
        n_tests++; if (fb.pc !== 32'hBFC0_0004) begin n_fail++; $display("FAIL run1_pc got %h want bfc00004", fb.pc); end
        cycle();
        n_tests++; if (fb.pc !== 32'hBFC0_0008) begin n_fail++; $display("FAIL run2_pc got %h want bfc00008", fb.pc); end
    endtask

    task automatic test_branch_stalled();
        stall = 6'b000001; flush_i = 1; flush_pc_i = 32'h100;
        cycle();
        flush_i = 0; branch_flag_i = 1; branch_target_addr_i = 32'h400;
        cycle();
        branch_flag_i = 0;
        n_tests++; if (pend_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_pend got %b want 1", pend_valid_o); end
        n_tests++; if (fb.pc !== 32'h100) begin n_fail++; $display("FAIL stall_hold got %h want 100", fb.pc); end
        n_tests++; if (fb.inst_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b want 0", fb.inst_req_o); end
        cycle();
        n_tests++; if (fb.pc !== 32'h100) begin n_fail++; $display("FAIL stall_hold2 got %h want 100", fb.pc); end
        stall = '0; fb.addr_ok_i = 1;
        cycle();
        n_tests++; if (fb.pc !== 32'h400) begin n_fail++; $display("FAIL pend_consume got %h want 400", fb.pc); end
        n_tests++; if (pend_valid_o !== 1'b0) begin n_fail++; $display("FAIL pend_clear got %b want 0", pend_valid_o); end
    endtask

    task automatic test_backpressure();
        fb.addr_ok_i = 0; flush_i = 1; flush_pc_i = 32'h200;
        cycle();
        flush_i = 0;
        n_tests++; if (fb.pc !== 32'h200) begin n_fail++; $display("FAIL bp_flush got %h want 200", fb.pc); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_tests++; if (fb.pc !== 32'h200) begin n_fail++; $display("FAIL bp_hold%0d got %h want 200", i, fb.pc); end
            n_tests++; if (fb.inst_req_o !== 1'b1) begin n_fail++; $display("FAIL bp_req%0d got %b want 1", i, fb.inst_req_o); end
        end
        fb.addr_ok_i = 1;
        cycle();
        n_tests++; if (fb.pc !== 32'h204) begin n_fail++; $display("FAIL bp_release got %h want 204", fb.pc); end
    endtask

    task automatic test_flush_priority();
        stall = 6'b000001; flush_i = 1; flush_pc_i = 32'h100;
        cycle();
        flush_i = 0; branch_flag_i = 1; branch_target_addr_i = 32'h400;
        cycle();
        flush_i = 1; flush_pc_i = 32'h180; branch_target_addr_i = 32'h300;
        cycle();
        flush_i = 0; branch_flag_i = 0;
        n_tests++; if (fb.pc !== 32'h180) begin n_fail++; $display("FAIL flush_pc got %h want 180", fb.pc); end
        n_tests++; if (pend_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_pend got %b want 0", pend_valid_o); end
        stall = '0; fb.addr_ok_i = 1;
        cycle();
        n_tests++; if (fb.pc !== 32'h184) begin n_fail++; $display("FAIL flush_drop got %h want 184", fb.pc); end
    endtask

    task automatic test_wrap_misalign();
        fb.addr_ok_i = 0; flush_i = 1; flush_pc_i = 32'hFFFF_FFFC;
        cycle();
        flush_i = 0; fb.addr_ok_i = 1;
        cycle();
        n_tests++; if (fb.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", fb.pc); end
        n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL wrap_mis got %b want 0", misalign_o); end
        branch_flag_i = 1; branch_target_addr_i = 32'h102;
        cycle();
        branch_flag_i = 0;
        n_tests++; if (fb.pc !== 32'h102) begin n_fail++; $display("FAIL mis_pc got %h want 102", fb.pc); end
        n_tests++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", misalign_o); end
        cycle();
        n_tests++; if (fb.pc !== 32'h106) begin n_fail++; $display("FAIL mis_adv got %h want 106", fb.pc); end
        n_tests++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_adv_flag got %b want 1", misalign_o); end
    endtask

    task automatic test_back_to_back();
        stall = 6'b000001; flush_i = 1; flush_pc_i = 32'h300;
        cycle();
        flush_i = 0; branch_flag_i = 1; branch_target_addr_i = 32'h500;
        cycle();
        branch_target_addr_i = 32'h600;
        cycle();
        branch_flag_i = 0;
        n_tests++; if (fb.pc !== 32'h300) begin n_fail++; $display("FAIL ovr_hold got %h want 300", fb.pc); end
        stall = '0; fb.addr_ok_i = 1;
        cycle();
        n_tests++; if (fb.pc !== 32'h600) begin n_fail++; $display("FAIL ovr_newest got %h want 600", fb.pc); end
        stall = 6'b000001; branch_flag_i = 1; branch_target_addr_i = 32'h700;
        cycle();
        stall = '0; branch_target_addr_i = 32'h800;
        cycle();
        branch_flag_i = 0;
        n_tests++; if (fb.pc !== 32'h800) begin n_fail++; $display("FAIL live_wins got %h want 800", fb.pc); end
        n_tests++; if (pend_valid_o !== 1'b0) begin n_fail++; $display("FAIL live_clear got %b want 0", pend_valid_o); end
        cycle();
        n_tests++; if (fb.pc !== 32'h804) begin n_fail++; $display("FAIL live_next got %h want 804", fb.pc); end
    endtask

    task automatic test_reset_pending();
        stall = 6'b000001; branch_flag_i = 1; branch_target_addr_i = 32'h900;
        cycle();
        branch_flag_i = 0;
        n_tests++; if (pend_valid_o !== 1'b1) begin n_fail++; $display("FAIL rp_pend got %b want 1", pend_valid_o); end
        rst = 1;
        cycle();
        n_tests++; if (fb.pc !== RV) begin n_fail++; $display("FAIL rp_pc got %h want %h", fb.pc, RV); end
        n_tests++; if (pend_valid_o !== 1'b0) begin n_fail++; $display("FAIL rp_clear got %b want 0", pend_valid_o); end
        n_tests++; if (fb.ce !== 1'b0) begin n_fail++; $display("FAIL rp_ce got %b want 0", fb.ce); end
        rst = 0; stall = '0; fb.addr_ok_i = 1;
        cycle(); cycle(); cycle();
        n_tests++; if (fb.pc !== RV + 32'd4) begin n_fail++; $display("FAIL rp_restart got %h want %h", fb.pc, RV + 32'd4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst                  = ($urandom_range(0, 59) == 0);
            stall                = 6'($urandom);
            flush_i              = ($urandom_range(0, 9) == 0);
            flush_pc_i           = $urandom;
            branch_flag_i        = ($urandom_range(0, 3) == 0);
            branch_target_addr_i = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                flush_pc_i[1:0]           = 2'b00;
                branch_target_addr_i[1:0] = 2'b00;
            end
            fb.addr_ok_i = ($urandom_range(0, 3) != 0);
            cycle();
            n_tests++; if (fb.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, fb.pc, m_pc); end
            n_tests++; if (fb.ce !== (m_cycles != 0)) begin n_fail++; $display("FAIL rnd_ce[%0d] got %b want %b", i, fb.ce, m_cycles != 0); end
            n_tests++; if (fb.inst_req_o !== ((m_cycles != 0) && !stall[0])) begin
                n_fail++; $display("FAIL rnd_req[%0d] got %b want %b", i, fb.inst_req_o, (m_cycles != 0) && !stall[0]);
            end
            n_tests++; if (pend_valid_o !== m_pend) begin n_fail++; $display("FAIL rnd_pend[%0d] got %b want %b", i, pend_valid_o, m_pend); end
            n_tests++; if (misalign_o !== (m_pc[1:0] != 2'b00)) begin
                n_fail++; $display("FAIL rnd_mis[%0d] got %b want %b", i, misalign_o, m_pc[1:0] != 2'b00);
            end
        end
        rst = 0; flush_i = 0; branch_flag_i = 0;
    endtask

    task automatic test_param_sweep();
        stall2 = '0; flush2 = 0; flush_pc2 = '0; branch2 = 0; target2 = '0; fb2.addr_ok_i = 1;
        rst2 = 1;
        cycle(); cycle();
        n_tests++; if (fb2.pc !== RV2) begin n_fail++; $display("FAIL w16_reset_pc got %h want fffe", fb2.pc); end
        n_tests++; if (fb2.ce !== 1'b0) begin n_fail++; $display("FAIL w16_reset_ce got %b want 0", fb2.ce); end
        rst2 = 0;
        cycle();
        n_tests++; if (fb2.ce !== 1'b1) begin n_fail++; $display("FAIL w16_boot_ce got %b want 1", fb2.ce); end
        n_tests++; if (fb2.pc !== 16'hFFFE) begin n_fail++; $display("FAIL w16_seq0 got %h want fffe", fb2.pc); end
        cycle();
        n_tests++; if (fb2.pc !== 16'hFFFE) begin n_fail++; $display("FAIL w16_seq1 got %h want fffe", fb2.pc); end
        cycle();
        n_tests++; if (fb2.pc !== 16'h0000) begin n_fail++; $display("FAIL w16_seq2 got %h want 0000", fb2.pc); end
        cycle();
        n_tests++; if (fb2.pc !== 16'h0002) begin n_fail++; $display("FAIL w16_seq3 got %h want 0002", fb2.pc); end
        n_tests++; if (misalign2 !== 1'b0) begin n_fail++; $display("FAIL w16_mis got %b want 0", misalign2); end
        branch2 = 1; target2 = 16'h0011;
        cycle();
        branch2 = 0;
        n_tests++; if (fb2.pc !== 16'h0011) begin n_fail++; $display("FAIL w16_br got %h want 0011", fb2.pc); end
        n_tests++; if (misalign2 !== 1'b1) begin n_fail++; $display("FAIL w16_br_mis got %b want 1", misalign2); end
    endtask

    initial begin
        rst = 1; stall = '0; flush_i = 0; flush_pc_i = '0; branch_flag_i = 0;
        branch_target_addr_i = '0; fb.addr_ok_i = 0;
        rst2 = 1; stall2 = '0; flush2 = 0; flush_pc2 = '0; branch2 = 0; target2 = '0;
        fb2.addr_ok_i = 0;
        test_reset();
        test_branch_stalled();
        test_backpressure();
        test_flush_priority();
        test_wrap_misalign();
        test_back_to_back();
        test_reset_pending();
        test_random();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
